// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has strict priority, the CPU uses idle slots
// through a one-entry request buffer; read data is routed back by an owner-tagged pipeline.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_rvalid,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_overrun,
  output logic                  cpu_starved,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int L  = RD_LATENCY;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    WAIT_RD = 2'd2
  } buf_state_t;

  buf_state_t            state, state_next;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [L:0]            pipe_vld;
  logic [L:0]            pipe_cpu;
  logic [CW-1:0]         starve_cnt;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic                  cpu_grant;
  logic                  cpu_ret;
  logic                  accept;
  logic                  lost_slot;

  assign cpu_grant = (state == PENDING) && !disp_req;
  assign lost_slot = (state == PENDING) && disp_req;
  assign cpu_ret   = pipe_vld[L] && pipe_cpu[L];
  // A granted write keeps the buffer busy until its RAM cycle has been issued.
  assign cpu_busy  = (state != EMPTY) || ram_we;
  assign accept    = cpu_req && !cpu_busy;

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept)    state_next = PENDING;
      PENDING: if (cpu_grant) state_next = buf_we ? EMPTY : WAIT_RD;
      WAIT_RD: if (cpu_ret)   state_next = EMPTY;
      default:                state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        buf_we    <= cpu_we;
        buf_addr  <= cpu_addr;
        buf_wdata <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      pipe_vld  <= '0;
      pipe_cpu  <= '0;
    end else begin
      ram_we <= 1'b0;
      if (disp_req) begin
        ram_addr <= disp_addr;
      end else if (cpu_grant) begin
        ram_addr <= buf_addr;
        ram_we   <= buf_we;
        if (buf_we) ram_wdata <= buf_wdata;
      end
      pipe_vld <= {pipe_vld[L-1:0], disp_req || (cpu_grant && !buf_we)};
      pipe_cpu <= {pipe_cpu[L-1:0], !disp_req};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt  <= '0;
      cpu_starved <= 1'b0;
      cpu_overrun <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      if (cpu_grant) begin
        starve_cnt <= '0;
      end else if (lost_slot && starve_cnt != CW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (lost_slot && starve_cnt == CW'(STARVE_LIMIT - 1)) cpu_starved <= 1'b1;
      if (cpu_req && cpu_busy) cpu_overrun <= 1'b1;
      if (cpu_ret) cpu_rdata_q <= ram_rdata;
    end
  end

  assign disp_rvalid = pipe_vld[L] && !pipe_cpu[L];
  assign disp_rdata  = disp_rvalid ? ram_rdata : '0;
  assign cpu_rvalid  = cpu_ret;
  assign cpu_rdata   = cpu_ret ? ram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter: schedules are planned up front, expected
// returns/writes are queued at issue time and popped by a separate monitor.
module tb_vram_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int L     = 1;
  localparam int LIMIT = 64;
  localparam int MAXN  = 512;
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_overrun;
  logic          cpu_starved;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  vram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_overrun(cpu_overrun), .cpu_starved(cpu_starved),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Background VRAM contents for never-written words.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] lo;
    lo = a[7:0] + 8'h1C;
    return lo ^ {2'b00, a[13:8]};
  endfunction

  // Environment RAM with RD_LATENCY read latency.
  bit   [DW-1:0] vram [0:(1<<AW)-1];
  bit            vwr  [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:L-1];
  assign ram_rdata = rpipe[L-1];
  always @(posedge clk) begin
    if (ram_we) begin
      vram[ram_addr] <= ram_wdata;
      vwr[ram_addr]  <= 1'b1;
    end
    rpipe[0] <= vwr[ram_addr] ? vram[ram_addr] : pat(ram_addr);
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t dq[$];
  exp_t cq[$];
  exp_t wq[$];

  logic [DW-1:0] ref_mem [int];
  bit            dsched [0:MAXN-1];
  logic [AW-1:0] daddr  [0:MAXN-1];
  bit            csched [0:MAXN-1];
  bit            cwe    [0:MAXN-1];
  logic [AW-1:0] caddr  [0:MAXN-1];
  logic [DW-1:0] cwdata [0:MAXN-1];
  bit            exp_busy [0:MAXN-1];

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  bit            checking = 1'b0;
  int            free_at;
  int            overrun_from;
  int            starved_from;
  logic [DW-1:0] last_rd_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  // Reference model: the CPU request is served in the first display-free slot after it.
  task automatic plan_cpu(input int c);
    int   g;
    int   fr;
    exp_t e;
    if (c < free_at) begin
      if (overrun_from > c + 1) overrun_from = c + 1;
      return;
    end
    g = c + 1;
    while (g < MAXN - 1 && dsched[g]) g++;
    if (g - (c + 1) >= LIMIT && starved_from > c + 1 + LIMIT) starved_from = c + 1 + LIMIT;
    e.a = caddr[c];
    if (cwe[c]) begin
      ref_mem[int'(caddr[c])] = cwdata[c];
      e.cyc = g + 1;
      e.d   = cwdata[c];
      wq.push_back(e);
      fr = g + 2;
    end else begin
      e.cyc = g + 1 + L;
      e.d   = ref_rd(caddr[c]);
      cq.push_back(e);
      last_rd_exp = e.d;
      fr = g + 2 + L;
    end
    for (int k = c + 1; k < fr && k < MAXN; k++) exp_busy[k] = 1'b1;
    free_at = fr;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      chk("cpu_busy", 32'(cpu_busy), 32'(exp_busy[cyc]));
      chk("cpu_overrun", 32'(cpu_overrun), 32'(cyc >= overrun_from));
      chk("cpu_starved", 32'(cpu_starved), 32'(cyc >= starved_from));
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk("disp_rvalid_missing", 32'(cyc), 32'(dq[0].cyc));
        void'(dq.pop_front());
      end
      if (cq.size() > 0 && cq[0].cyc < cyc) begin
        chk("cpu_rvalid_missing", 32'(cyc), 32'(cq[0].cyc));
        void'(cq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("ram_we_missing", 32'(cyc), 32'(wq[0].cyc));
        void'(wq.pop_front());
      end
      if (disp_rvalid) begin
        if (dq.size() == 0) chk("disp_rvalid_unexpected", 32'(disp_rvalid), 32'(0));
        else begin
          e = dq.pop_front();
          chk("disp_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("disp_rdata", 32'(disp_rdata), 32'(e.d));
        end
      end
      if (cpu_rvalid) begin
        if (cq.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'(0));
        else begin
          e = cq.pop_front();
          chk("cpu_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("cpu_rdata", 32'(cpu_rdata), 32'(e.d));
        end
      end
      if (ram_we) begin
        if (wq.size() == 0) chk("ram_we_unexpected", 32'(ram_we), 32'(0));
        else begin
          e = wq.pop_front();
          chk("ram_we_cycle", 32'(cyc), 32'(e.cyc));
          chk("ram_addr", 32'(ram_addr), 32'(e.a));
          chk("ram_wdata", 32'(ram_wdata), 32'(e.d));
        end
      end
    end
  end

  task automatic idle_inputs();
    disp_req  = 1'b0;
    disp_addr = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_a", 32'({disp_rvalid, disp_rdata, cpu_busy, cpu_rvalid, cpu_rdata,
                                cpu_overrun, cpu_starved}), 32'(0));
    chk("reset_outputs_b", 32'({ram_addr, ram_we, ram_wdata}), 32'(0));
    dq.delete();
    cq.delete();
    wq.delete();
    free_at      = 0;
    overrun_from = NEVER;
    starved_from = NEVER;
    last_rd_exp  = '0;
    for (int k = 0; k < MAXN; k++) exp_busy[k] = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_phase(input int n, input bit drain);
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      cyc       = c;
      checking  = 1'b1;
      disp_req  = dsched[c];
      disp_addr = daddr[c];
      cpu_req   = csched[c];
      cpu_we    = cwe[c];
      cpu_addr  = caddr[c];
      cpu_wdata = cwdata[c];
      if (dsched[c]) dq.push_back('{c + 1 + L, daddr[c], pat(daddr[c])});
      if (csched[c]) plan_cpu(c);
    end
    @(posedge clk);
    #1;
    checking = 1'b0;
    idle_inputs();
    if (drain) begin
      chk("disp_queue_drained", 32'(dq.size()), 32'(0));
      chk("cpu_queue_drained", 32'(cq.size()), 32'(0));
      chk("write_queue_drained", 32'(wq.size()), 32'(0));
      chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_rd_exp));
    end
  endtask

  task automatic clear_sched();
    for (int k = 0; k < MAXN; k++) begin
      dsched[k] = 1'b0;
      daddr[k]  = '0;
      csched[k] = 1'b0;
      cwe[k]    = 1'b0;
      caddr[k]  = '0;
      cwdata[k] = '0;
    end
  endtask

  task automatic set_cpu(input int c, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    csched[c] = 1'b1;
    cwe[c]    = we;
    caddr[c]  = a;
    cwdata[c] = d;
  endtask

  task automatic set_disp(input int start, input int len);
    for (int k = start; k < start + len; k++) begin
      dsched[k] = 1'b1;
      daddr[k]  = AW'($urandom_range(16'h2000, 16'h3FFF));
    end
  endtask

  // Display traffic stays in the upper half; CPU traffic in the lower half.
  task automatic rand_sched(input int n, input int dpct, input int cpct);
    clear_sched();
    for (int k = 0; k < n - 12; k++) begin
      if ($urandom_range(0, 99) < dpct) set_disp(k, 1);
      if ($urandom_range(0, 99) < cpct)
        set_cpu(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 16'h1FFF)),
                DW'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    clear_sched();

    clear_sched(); set_cpu(5, 1'b1, 14'h0123, 8'h3A); run_phase(40, 1'b1);
    clear_sched(); set_cpu(5, 1'b0, 14'h0040, 8'h00); run_phase(40, 1'b1);
    clear_sched(); set_cpu(5, 1'b0, 14'h0041, 8'h00); set_disp(6, 10); run_phase(60, 1'b1);
    clear_sched(); set_cpu(5, 1'b1, 14'h0300, 8'h77); set_disp(6, 70); run_phase(110, 1'b1);
    clear_sched(); set_cpu(5, 1'b1, 14'h0200, 8'hA5); set_cpu(6, 1'b0, 14'h0201, 8'h00);
    run_phase(40, 1'b1);
    // Read still in flight when the next phase's reset hits.
    clear_sched(); set_cpu(5, 1'b0, 14'h0040, 8'h00); run_phase(7, 1'b0);
    clear_sched(); set_cpu(5, 1'b0, 14'h0040, 8'h00); run_phase(40, 1'b1);

    for (int p = 0; p < 4; p++) begin
      rand_sched(300, p * 30, 25);
      run_phase(300, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
